// File: rtl/cell_pkg.sv
// Shared definitions for the cell-state memory scheduler: grid geometry,
// scheduler state encoding and memory grant encoding.
package cell_pkg;

  localparam int ACTIVE_COLUMNS = 640;
  localparam int ACTIVE_ROWS    = 480;
  localparam int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS);

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_START = 2'd1,
    SCHED_RUN   = 2'd2
  } sched_state_t;

  typedef enum logic [1:0] {
    GRANT_DISPLAY = 2'd0,
    GRANT_ENGINE  = 2'd1,
    GRANT_PAINT   = 2'd2
  } mem_grant_t;

endpackage

// File: rtl/frame_divider.sv
// Modulo-UPDATE_DIVIDER vblank counter; flags the vblank pulse that makes an
// engine step due. Advances on every pulse regardless of pause state.
module frame_divider #(
  parameter int UPDATE_DIVIDER = 1
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic vblank_start_i,
  output logic step_due_o
);

  localparam int CNT_W = (UPDATE_DIVIDER > 1) ? $clog2(UPDATE_DIVIDER) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(UPDATE_DIVIDER - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (vblank_start_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign step_due_o = vblank_start_i && (cnt_q == LAST);

endmodule

// File: rtl/cell_mem_scheduler.sv
// Arbitrates the shared cell-state RAM between the display scan, the
// next-state engine (one step per UPDATE_DIVIDER frames) and the paint port.
module cell_mem_scheduler #(
  parameter int ACTIVE_COLUMNS = cell_pkg::ACTIVE_COLUMNS,
  parameter int ACTIVE_ROWS    = cell_pkg::ACTIVE_ROWS,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
  parameter int DATA_WIDTH     = 1,
  parameter int UPDATE_DIVIDER = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  enable_i,
  input  logic                  vblank_start_i,
  input  logic                  vblank_i,
  input  logic [ADDR_WIDTH-1:0] display_rd_address_i,
  output logic                  engine_ready_o,
  input  logic [ADDR_WIDTH-1:0] engine_rd_address_i,
  input  logic [ADDR_WIDTH-1:0] engine_wr_address_i,
  input  logic [DATA_WIDTH-1:0] engine_wr_data_i,
  input  logic                  engine_wr_en_i,
  input  logic                  engine_done_i,
  input  logic                  paint_req_i,
  input  logic [ADDR_WIDTH-1:0] paint_address_i,
  input  logic [DATA_WIDTH-1:0] paint_data_i,
  output logic                  paint_ack_o,
  output logic [ADDR_WIDTH-1:0] mem_rd_address_o,
  output logic [ADDR_WIDTH-1:0] mem_wr_address_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  output logic                  mem_wr_en_o,
  output logic                  display_valid_o,
  output logic                  overrun_o,
  output logic [15:0]           step_count_o
);

  import cell_pkg::*;

  sched_state_t state_q, state_d;
  mem_grant_t   grant;
  logic         step_due;
  logic         overrun_q, overrun_d;
  logic [15:0]  step_count_q, step_count_d;

  frame_divider #(
    .UPDATE_DIVIDER(UPDATE_DIVIDER)
  ) u_frame_divider (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .vblank_start_i (vblank_start_i),
    .step_due_o     (step_due)
  );

  // A due step outranks paint; paint is held off while reset is asserted so
  // the ack stays low even though the state register already reads IDLE.
  always_comb begin
    state_d        = state_q;
    grant          = GRANT_DISPLAY;
    engine_ready_o = 1'b0;
    paint_ack_o    = 1'b0;
    step_count_d   = step_count_q;
    case (state_q)
      SCHED_IDLE: begin
        if (step_due && enable_i) begin
          state_d = SCHED_START;
        end else if (paint_req_i && reset_n_i) begin
          grant       = GRANT_PAINT;
          paint_ack_o = 1'b1;
        end
      end
      SCHED_START: begin
        grant          = GRANT_ENGINE;
        engine_ready_o = 1'b1;
        state_d        = SCHED_RUN;
      end
      SCHED_RUN: begin
        grant = GRANT_ENGINE;
        if (engine_done_i) begin
          state_d      = SCHED_IDLE;
          step_count_d = step_count_q + 16'd1;
        end
      end
      default: state_d = SCHED_IDLE;
    endcase
    overrun_d = overrun_q || ((state_q != SCHED_IDLE) && !vblank_i);
  end

  always_comb begin
    mem_rd_address_o = display_rd_address_i;
    mem_wr_address_o = '0;
    mem_wr_data_o    = '0;
    mem_wr_en_o      = 1'b0;
    display_valid_o  = 1'b1;
    case (grant)
      GRANT_ENGINE: begin
        mem_rd_address_o = engine_rd_address_i;
        mem_wr_address_o = engine_wr_address_i;
        mem_wr_data_o    = engine_wr_data_i;
        mem_wr_en_o      = engine_wr_en_i;
        display_valid_o  = 1'b0;
      end
      GRANT_PAINT: begin
        mem_wr_address_o = paint_address_i;
        mem_wr_data_o    = paint_data_i;
        mem_wr_en_o      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= SCHED_IDLE;
      overrun_q    <= 1'b0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      overrun_q    <= overrun_d;
      step_count_q <= step_count_d;
    end
  end

  assign overrun_o    = overrun_q;
  assign step_count_o = step_count_q;

endmodule

// File: tb/tb_cell_mem_scheduler.sv
// Directed bench for cell_mem_scheduler: one instance with a divider of 1 and
// one with a divider of 3, both driven from the same stimulus.
module tb_cell_mem_scheduler;

  localparam int AW = 19;
  localparam int DW = 1;

  logic          clk = 1'b0;
  logic          reset_n, enable, vblank_start, vblank;
  logic [AW-1:0] display_rd_address, engine_rd_address, engine_wr_address, paint_address;
  logic [DW-1:0] engine_wr_data, paint_data;
  logic          engine_wr_en, engine_done, paint_req;

  logic          d1_ready, d1_ack, d1_wr_en, d1_valid, d1_overrun;
  logic [AW-1:0] d1_rd_addr, d1_wr_addr;
  logic [DW-1:0] d1_wr_data;
  logic [15:0]   d1_steps;
  logic          d3_ready, d3_ack, d3_wr_en, d3_valid, d3_overrun;
  logic [AW-1:0] d3_rd_addr, d3_wr_addr;
  logic [DW-1:0] d3_wr_data;
  logic [15:0]   d3_steps;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cell_mem_scheduler #(.UPDATE_DIVIDER(1)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .vblank_start_i(vblank_start),
    .vblank_i(vblank), .display_rd_address_i(display_rd_address), .engine_ready_o(d1_ready),
    .engine_rd_address_i(engine_rd_address), .engine_wr_address_i(engine_wr_address),
    .engine_wr_data_i(engine_wr_data), .engine_wr_en_i(engine_wr_en), .engine_done_i(engine_done),
    .paint_req_i(paint_req), .paint_address_i(paint_address), .paint_data_i(paint_data),
    .paint_ack_o(d1_ack), .mem_rd_address_o(d1_rd_addr), .mem_wr_address_o(d1_wr_addr),
    .mem_wr_data_o(d1_wr_data), .mem_wr_en_o(d1_wr_en), .display_valid_o(d1_valid),
    .overrun_o(d1_overrun), .step_count_o(d1_steps)
  );

  cell_mem_scheduler #(.UPDATE_DIVIDER(3)) dut3 (
    .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .vblank_start_i(vblank_start),
    .vblank_i(vblank), .display_rd_address_i(display_rd_address), .engine_ready_o(d3_ready),
    .engine_rd_address_i(engine_rd_address), .engine_wr_address_i(engine_wr_address),
    .engine_wr_data_i(engine_wr_data), .engine_wr_en_i(engine_wr_en), .engine_done_i(engine_done),
    .paint_req_i(paint_req), .paint_address_i(paint_address), .paint_data_i(paint_data),
    .paint_ack_o(d3_ack), .mem_rd_address_o(d3_rd_addr), .mem_wr_address_o(d3_wr_addr),
    .mem_wr_data_o(d3_wr_data), .mem_wr_en_o(d3_wr_en), .display_valid_o(d3_valid),
    .overrun_o(d3_overrun), .step_count_o(d3_steps)
  );

  // Each cycle: inputs change at the falling edge, outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic apply_reset();
    next_cycle();
    reset_n = 1'b0; enable = 1'b1; vblank_start = 1'b0; vblank = 1'b1;
    display_rd_address = 19'd77; engine_rd_address = '0; engine_wr_address = '0;
    engine_wr_data = '0; engine_wr_en = 1'b0; engine_done = 1'b0;
    paint_req = 1'b0; paint_address = '0; paint_data = '0;
    next_cycle(); next_cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    next_cycle();
    reset_n = 1'b0; paint_req = 1'b1; paint_address = 19'd9; paint_data = 1'b1;
    display_rd_address = 19'd123;
    settle();
    checks++; if (d1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", d1_ready); end
    checks++; if (d1_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0b want 0", d1_ack); end
    checks++; if (d1_wr_en !== 1'b0 || d1_wr_addr !== 19'd0 || d1_wr_data !== 1'b0) begin errors++; $display("FAIL reset_wr: en=%0b addr=%0d data=%0b want 0/0/0", d1_wr_en, d1_wr_addr, d1_wr_data); end
    checks++; if (d1_valid !== 1'b1) begin errors++; $display("FAIL reset_valid: got %0b want 1", d1_valid); end
    checks++; if (d1_rd_addr !== 19'd123) begin errors++; $display("FAIL reset_rd_addr: got %0d want 123", d1_rd_addr); end
    checks++; if (d1_steps !== 16'd0 || d1_overrun !== 1'b0) begin errors++; $display("FAIL reset_regs: steps=%0d overrun=%0b want 0/0", d1_steps, d1_overrun); end
    paint_req = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_step();
    apply_reset();
    next_cycle(); vblank_start = 1'b1; settle();
    checks++; if (d1_ready !== 1'b0 || d1_valid !== 1'b1) begin errors++; $display("FAIL step_pulse_cycle: ready=%0b valid=%0b want 0/1", d1_ready, d1_valid); end
    next_cycle(); vblank_start = 1'b0;
    engine_rd_address = 19'd100; engine_wr_address = 19'd200; engine_wr_data = 1'b1; engine_wr_en = 1'b1;
    settle();
    checks++; if (d1_ready !== 1'b1) begin errors++; $display("FAIL step_ready: got %0b want 1", d1_ready); end
    checks++; if (d1_rd_addr !== 19'd100 || d1_wr_addr !== 19'd200 || d1_wr_en !== 1'b1 || d1_wr_data !== 1'b1) begin errors++; $display("FAIL step_engine_mux: rd=%0d wr=%0d en=%0b data=%0b want 100/200/1/1", d1_rd_addr, d1_wr_addr, d1_wr_en, d1_wr_data); end
    checks++; if (d1_valid !== 1'b0) begin errors++; $display("FAIL step_start_valid: got %0b want 0", d1_valid); end
    next_cycle(); settle();
    checks++; if (d1_ready !== 1'b0 || d1_valid !== 1'b0) begin errors++; $display("FAIL step_run: ready=%0b valid=%0b want 0/0", d1_ready, d1_valid); end
    next_cycle(); engine_done = 1'b1; engine_wr_address = 19'd201; settle();
    checks++; if (d1_wr_en !== 1'b1 || d1_wr_addr !== 19'd201 || d1_valid !== 1'b0) begin errors++; $display("FAIL step_done_write: en=%0b addr=%0d valid=%0b want 1/201/0", d1_wr_en, d1_wr_addr, d1_valid); end
    next_cycle(); engine_done = 1'b0; engine_wr_en = 1'b0; settle();
    checks++; if (d1_valid !== 1'b1 || d1_rd_addr !== 19'd77 || d1_wr_en !== 1'b0) begin errors++; $display("FAIL step_back_to_display: valid=%0b rd=%0d en=%0b want 1/77/0", d1_valid, d1_rd_addr, d1_wr_en); end
    checks++; if (d1_steps !== 16'd1) begin errors++; $display("FAIL step_count: got %0d want 1", d1_steps); end
  endtask

  task automatic pulse_d3(input bit expect_ready, input int idx);
    next_cycle(); vblank_start = 1'b1;
    next_cycle(); vblank_start = 1'b0; settle();
    checks++; if (d3_ready !== expect_ready) begin errors++; $display("FAIL divider_pulse%0d: ready=%0b want %0b", idx, d3_ready, expect_ready); end
    if (expect_ready) begin
      next_cycle(); engine_done = 1'b1;
      next_cycle(); engine_done = 1'b0;
    end
  endtask

  task automatic test_divider();
    apply_reset();
    for (int k = 1; k <= 5; k++) pulse_d3(k == 3, k);
    enable = 1'b0;
    pulse_d3(1'b0, 6);
    enable = 1'b1;
    pulse_d3(1'b0, 7);
    pulse_d3(1'b0, 8);
    pulse_d3(1'b1, 9);
    settle();
    checks++; if (d3_steps !== 16'd2) begin errors++; $display("FAIL divider_steps: got %0d want 2", d3_steps); end
  endtask

  task automatic test_paint();
    apply_reset();
    next_cycle(); paint_req = 1'b1; paint_address = 19'd320; paint_data = 1'b1; settle();
    checks++; if (d1_ack !== 1'b1 || d1_wr_en !== 1'b1 || d1_wr_addr !== 19'd320 || d1_wr_data !== 1'b1) begin errors++; $display("FAIL paint_idle: ack=%0b en=%0b addr=%0d data=%0b want 1/1/320/1", d1_ack, d1_wr_en, d1_wr_addr, d1_wr_data); end
    next_cycle(); paint_req = 1'b0; settle();
    checks++; if (d1_ack !== 1'b0 || d1_wr_en !== 1'b0 || d1_wr_addr !== 19'd0) begin errors++; $display("FAIL paint_release: ack=%0b en=%0b addr=%0d want 0/0/0", d1_ack, d1_wr_en, d1_wr_addr); end
    next_cycle(); vblank_start = 1'b1;
    next_cycle(); vblank_start = 1'b0;
    next_cycle(); paint_req = 1'b1; paint_address = 19'd7; settle();
    checks++; if (d1_ack !== 1'b0 || d1_valid !== 1'b0) begin errors++; $display("FAIL paint_run_stall: ack=%0b valid=%0b want 0/0", d1_ack, d1_valid); end
    next_cycle(); engine_done = 1'b1; settle();
    checks++; if (d1_ack !== 1'b0 || d1_wr_en !== 1'b0) begin errors++; $display("FAIL paint_done_stall: ack=%0b en=%0b want 0/0", d1_ack, d1_wr_en); end
    next_cycle(); engine_done = 1'b0; settle();
    checks++; if (d1_ack !== 1'b1 || d1_wr_addr !== 19'd7) begin errors++; $display("FAIL paint_after_run: ack=%0b addr=%0d want 1/7", d1_ack, d1_wr_addr); end
    next_cycle(); paint_req = 1'b0;
  endtask

  task automatic test_paint_vs_step();
    int acks;
    apply_reset();
    acks = 0;
    next_cycle(); vblank_start = 1'b1; paint_req = 1'b1; paint_address = 19'd55; paint_data = 1'b1; settle();
    checks++; if (d1_ack !== 1'b0 || d1_wr_en !== 1'b0) begin errors++; $display("FAIL collide_step_wins: ack=%0b en=%0b want 0/0", d1_ack, d1_wr_en); end
    next_cycle(); vblank_start = 1'b0; settle();
    checks++; if (d1_ready !== 1'b1 || d1_ack !== 1'b0) begin errors++; $display("FAIL collide_start: ready=%0b ack=%0b want 1/0", d1_ready, d1_ack); end
    next_cycle(); engine_done = 1'b1; settle();
    acks += d1_ack;
    next_cycle(); engine_done = 1'b0; settle();
    checks++; if (d1_ack !== 1'b1 || d1_wr_addr !== 19'd55) begin errors++; $display("FAIL collide_ack_after_done: ack=%0b addr=%0d want 1/55", d1_ack, d1_wr_addr); end
    acks += d1_ack;
    next_cycle(); paint_req = 1'b0; settle();
    acks += d1_ack;
    checks++; if (acks != 1) begin errors++; $display("FAIL collide_ack_count: got %0d want 1", acks); end
  endtask

  task automatic test_overrun();
    apply_reset();
    next_cycle(); vblank_start = 1'b1;
    next_cycle(); vblank_start = 1'b0;
    next_cycle(); vblank = 1'b0; settle();
    checks++; if (d1_overrun !== 1'b0) begin errors++; $display("FAIL overrun_early: got %0b want 0", d1_overrun); end
    next_cycle(); vblank_start = 1'b1; settle();
    checks++; if (d1_overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %0b want 1", d1_overrun); end
    next_cycle(); vblank_start = 1'b0; settle();
    checks++; if (d1_ready !== 1'b0) begin errors++; $display("FAIL overrun_no_extra_ready: got %0b want 0", d1_ready); end
    next_cycle(); engine_done = 1'b1;
    next_cycle(); engine_done = 1'b0; settle();
    checks++; if (d1_overrun !== 1'b1 || d1_valid !== 1'b1 || d1_steps !== 16'd1) begin errors++; $display("FAIL overrun_after_done: overrun=%0b valid=%0b steps=%0d want 1/1/1", d1_overrun, d1_valid, d1_steps); end
    next_cycle(); settle();
    checks++; if (d1_ready !== 1'b0 || d1_valid !== 1'b1) begin errors++; $display("FAIL overrun_no_queued: ready=%0b valid=%0b want 0/1", d1_ready, d1_valid); end
    vblank = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    next_cycle(); vblank_start = 1'b1;
    next_cycle(); vblank_start = 1'b0;
    next_cycle(); engine_done = 1'b1;
    next_cycle(); engine_done = 1'b0; vblank_start = 1'b1;
    next_cycle(); vblank_start = 1'b0;
    next_cycle(); engine_wr_en = 1'b1; engine_wr_address = 19'd33; settle();
    checks++; if (d1_valid !== 1'b0 || d1_steps !== 16'd1) begin errors++; $display("FAIL midrun_setup: valid=%0b steps=%0d want 0/1", d1_valid, d1_steps); end
    #1 reset_n = 1'b0; #1;
    checks++; if (d1_valid !== 1'b1 || d1_rd_addr !== 19'd77 || d1_wr_en !== 1'b0 || d1_wr_addr !== 19'd0 || d1_ready !== 1'b0) begin errors++; $display("FAIL midrun_reset_outputs: valid=%0b rd=%0d en=%0b wr=%0d ready=%0b want 1/77/0/0/0", d1_valid, d1_rd_addr, d1_wr_en, d1_wr_addr, d1_ready); end
    checks++; if (d1_steps !== 16'd0 || d1_overrun !== 1'b0) begin errors++; $display("FAIL midrun_reset_regs: steps=%0d overrun=%0b want 0/0", d1_steps, d1_overrun); end
    next_cycle(); engine_wr_en = 1'b0; reset_n = 1'b1;
    next_cycle(); settle();
    checks++; if (d1_valid !== 1'b1 || d1_ready !== 1'b0) begin errors++; $display("FAIL midrun_after_release: valid=%0b ready=%0b want 1/0", d1_valid, d1_ready); end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; vblank_start = 1'b0; vblank = 1'b1;
    display_rd_address = '0; engine_rd_address = '0; engine_wr_address = '0;
    engine_wr_data = '0; engine_wr_en = 1'b0; engine_done = 1'b0;
    paint_req = 1'b0; paint_address = '0; paint_data = '0;
    test_reset();
    test_step();
    test_divider();
    test_paint();
    test_paint_vs_step();
    test_overrun();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
